// File: rtl/bullet_controller.sv
// Player bullet motion controller: synchronises the fire button, launches on a
// frame tick, moves the bullet upward once per frame, retires it and holds off re-arm.
module bullet_controller #(
  parameter int PLAYER_Y        = 440,
  parameter int SPAWN_DX        = 8,
  parameter int SPEED           = 4,
  parameter int TOP_Y           = 16,
  parameter int HIDE_Y          = 1000,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic [9:0] player_x,
  input  logic       hit,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic       active,
  output logic       fired
);

  localparam int CNT_W = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FLY  = 2'd1;
  localparam logic [1:0] S_COOL = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             fire_s1_q, fire_s2_q, fire_dly_q;
  logic             fire_req_q, fire_req_d;
  logic [9:0]       bx_q, bx_d;
  logic [9:0]       by_q, by_d;
  logic             active_q, active_d;
  logic             fired_q, fired_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             fire_edge;
  logic [10:0]      spawn_sum;
  logic [9:0]       spawn_x;

  assign fire_edge = fire_s2_q & ~fire_dly_q;

  // Sum kept in 11 bits so a cannon near x=1023 cannot wrap before the clamp.
  assign spawn_sum = {1'b0, player_x} + 11'(SPAWN_DX);
  assign spawn_x   = (spawn_sum > 11'd639) ? 10'd639 : spawn_sum[9:0];

  always_comb begin
    state_d    = state_q;
    fire_req_d = fire_req_q;
    bx_d       = bx_q;
    by_d       = by_q;
    active_d   = active_q;
    fired_d    = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        active_d = 1'b0;
        by_d     = 10'(HIDE_Y);
        if (frame_tick && fire_req_q) begin
          bx_d       = spawn_x;
          by_d       = 10'(PLAYER_Y);
          active_d   = 1'b1;
          fired_d    = 1'b1;
          fire_req_d = 1'b0;
          state_d    = S_FLY;
        end else if (fire_edge) begin
          fire_req_d = 1'b1;
        end
      end
      S_FLY: begin
        // Retire before stepping so y never drops below TOP_Y or wraps.
        if (hit || (frame_tick && (by_q < 10'(TOP_Y + SPEED)))) begin
          by_d     = 10'(HIDE_Y);
          active_d = 1'b0;
          cnt_d    = CNT_W'(COOLDOWN_FRAMES);
          state_d  = S_COOL;
        end else if (frame_tick) begin
          by_d = by_q - 10'(SPEED);
        end
      end
      S_COOL: begin
        active_d = 1'b0;
        by_d     = 10'(HIDE_Y);
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else if (frame_tick) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        active_d = 1'b0;
        by_d     = 10'(HIDE_Y);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fire_s1_q  <= 1'b0;
      fire_s2_q  <= 1'b0;
      fire_dly_q <= 1'b0;
      fire_req_q <= 1'b0;
      bx_q       <= '0;
      by_q       <= 10'(HIDE_Y);
      active_q   <= 1'b0;
      fired_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fire_s1_q  <= fire;
      fire_s2_q  <= fire_s1_q;
      fire_dly_q <= fire_s2_q;
      fire_req_q <= fire_req_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      active_q   <= active_d;
      fired_q    <= fired_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bullet_x = bx_q;
  assign bullet_y = by_q;
  assign active   = active_q;
  assign fired    = fired_q;

endmodule

// File: tb/tb_bullet_controller.sv
// Bench for bullet_controller: launch table, hand-written flight/cooldown/reset
// sequences and randomized traffic, all checked against a frame-level model.
module tb_bullet_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       fire = 1'b0;
  logic [9:0] player_x = '0;
  logic       hit = 1'b0;
  logic [9:0] bullet_x;
  logic [9:0] bullet_y;
  logic       active;
  logic       fired;

  bullet_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .fire       (fire),
    .player_x   (player_x),
    .hit        (hit),
    .bullet_x   (bullet_x),
    .bullet_y   (bullet_y),
    .active     (active),
    .fired      (fired)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int fired_seen = 0;

  // Reference model: bullet mode (0 parked, 1 flying, 2 cooling), pending
  // request, position, frames left in cooldown, and fire button history.
  int m_mode = 0, m_req = 0, m_x = 0, m_y = 440, m_cnt = 0, m_fired = 0;
  int hist [3] = '{0, 0, 0};

  typedef struct {
    int px;
    int exp_x;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int rise;
    if (!rst_n) begin
      m_mode = 0; m_req = 0; m_x = 0; m_cnt = 0; m_fired = 0;
      hist = '{0, 0, 0};
    end else begin
      // A press becomes visible two clocks after sampling, as a 0->1 change.
      rise = (hist[1] == 1 && hist[2] == 0) ? 1 : 0;
      m_fired = 0;
      case (m_mode)
        0: begin
          if (frame_tick && m_req == 1) begin
            m_x = (int'(player_x) + 8 > 639) ? 639 : int'(player_x) + 8;
            m_y = 440; m_mode = 1; m_fired = 1; m_req = 0;
          end else if (rise == 1) m_req = 1;
        end
        1: begin
          if (hit || (frame_tick && m_y - 4 < 16)) begin
            m_mode = 2; m_cnt = 8;
          end else if (frame_tick) m_y = m_y - 4;
        end
        default: begin
          if (m_cnt == 0) m_mode = 0;
          else if (frame_tick) m_cnt = m_cnt - 1;
        end
      endcase
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = int'(fire);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    if (fired) fired_seen++;
    chk("model_x", int'(bullet_x), m_x);
    chk("model_y", int'(bullet_y), (m_mode == 1) ? m_y : 1000);
    chk("model_active", int'(active), (m_mode == 1) ? 1 : 0);
    chk("model_fired", int'(fired), m_fired);
  endtask

  task automatic tick();
    frame_tick = 1'b1; step(); frame_tick = 1'b0; step(); step();
  endtask

  task automatic press();
    fire = 1'b1; repeat (4) step(); fire = 1'b0; repeat (2) step();
  endtask

  task automatic do_hit();
    hit = 1'b1; step(); hit = 1'b0; step();
  endtask

  task automatic launch(input int px);
    player_x = 10'(px);
    press();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("launch_fired", int'(fired), 1);
    chk("launch_active", int'(active), 1);
    chk("launch_y", int'(bullet_y), 440);
    step();
    chk("fired_one_cycle", int'(fired), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{100, 108};
    tbl[1] = '{0, 8};
    tbl[2] = '{631, 639};
    tbl[3] = '{636, 639};
    tbl[4] = '{1023, 639};
    tbl[5] = '{500, 508};

    // Reset and idle frames
    rst_n = 1'b0; repeat (3) step();
    chk("reset_y", int'(bullet_y), 1000);
    chk("reset_x", int'(bullet_x), 0);
    chk("reset_active", int'(active), 0);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("idle_y", int'(bullet_y), 1000);
    chk("idle_no_fired", fired_seen, 0);

    // Launch table: spawn x with clamp
    for (int i = 0; i < 6; i++) begin
      launch(tbl[i].px);
      chk($sformatf("spawn_x[%0d]", i), int'(bullet_x), tbl[i].exp_x);
      player_x = 10'd3;
      tick();
      chk($sformatf("x_frozen[%0d]", i), int'(bullet_x), tbl[i].exp_x);
      chk($sformatf("y_step[%0d]", i), int'(bullet_y), 436);
      do_hit();
      chk($sformatf("hit_hidden[%0d]", i), int'(bullet_y), 1000);
      repeat (9) tick();
    end

    // Full flight to the top
    launch(100);
    for (int k = 1; k <= 107; k++) begin
      tick();
      if (k == 1) chk("flight_y1", int'(bullet_y), 436);
      if (k == 106) chk("flight_y106", int'(bullet_y), 16);
      if (k == 106) chk("flight_active106", int'(active), 1);
    end
    chk("top_retire_y", int'(bullet_y), 1000);
    chk("top_retire_active", int'(active), 0);
    repeat (8) tick();
    launch(200);
    chk("refire_after_cool_x", int'(bullet_x), 208);

    // Hit coincident with frame_tick at y=200
    for (int k = 0; k < 60; k++) tick();
    chk("pre_hit_y", int'(bullet_y), 200);
    hit = 1'b1; frame_tick = 1'b1; step(); hit = 1'b0; frame_tick = 1'b0;
    chk("hit_prio_y", int'(bullet_y), 1000);
    chk("hit_prio_active", int'(active), 0);
    // Still cooling: a tick right away must not launch even with fire held earlier
    repeat (9) tick();

    // Presses during flight and cooldown are dropped
    launch(300);
    press();
    tick();
    do_hit();
    press();
    fired_seen = 0;
    repeat (9) tick();
    repeat (5) tick();
    chk("suppressed_fired", fired_seen, 0);
    chk("suppressed_active", int'(active), 0);
    launch(50);
    chk("new_press_x", int'(bullet_x), 58);

    // Reset mid-flight, then hit while parked
    repeat (3) tick();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("rst_mid_y", int'(bullet_y), 1000);
    chk("rst_mid_active", int'(active), 0);
    chk("rst_mid_x", int'(bullet_x), 0);
    hit = 1'b1; frame_tick = 1'b1; step(); hit = 1'b0; frame_tick = 1'b0;
    chk("idle_hit_active", int'(active), 0);
    chk("idle_hit_y", int'(bullet_y), 1000);
    step();

    // Randomized traffic with hits and occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) fire = ~fire;
      if ($urandom_range(0, 49) == 0) player_x = 10'($urandom_range(0, 1023));
      frame_tick = ($urandom_range(0, 5) == 0);
      hit = ($urandom_range(0, 40) == 0);
      rst_n = ($urandom_range(0, 999) != 0);
      step();
      frame_tick = 1'b0; hit = 1'b0; rst_n = 1'b1;
    end
    // Randomized traffic without hits so flights reach the top
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 29) == 0) fire = ~fire;
      if ($urandom_range(0, 49) == 0) player_x = 10'($urandom_range(0, 1023));
      frame_tick = ($urandom_range(0, 2) == 0);
      step();
      frame_tick = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
